// File: rtl/sub_sat_pipe_8bit_pkg.sv
// Shared constants and the stage-1 payload type for the saturating subtract pipeline.
package sub_sat_pipe_8bit_pkg;

  localparam int DATA_W = 8;

  localparam logic signed [DATA_W-1:0] SMAX = 8'sh7F;
  localparam logic signed [DATA_W-1:0] SMIN = 8'sh80;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } s1_payload_t;

endpackage

// File: rtl/sub_8bit_signed.sv
// Combinational signed 8-bit subtractor: result = A - B (mod 256) with signed overflow flag.
module sub_8bit_signed
  import sub_sat_pipe_8bit_pkg::*;
(
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic signed [DATA_W-1:0] result,
  output logic                     overflow
);

  always_comb begin
    result   = A - B;
    // Only operands of opposite sign can overflow; it shows as a sign flip away from A.
    overflow = (A[DATA_W-1] != B[DATA_W-1]) && (result[DATA_W-1] != A[DATA_W-1]);
  end

endmodule

// File: rtl/sub_sat_pipe_8bit.sv
// Two-stage valid/ready pipeline computing a - b with optional saturation and overflow statistics.
module sub_sat_pipe_8bit
  import sub_sat_pipe_8bit_pkg::*;
#(
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_result,
  output logic                     out_ovf,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
  output logic [CNT_W-1:0]         ovf_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer
  // holding valid keeps its payload stable until that edge, and ready may depend on
  // the downstream ready combinationally (in_ready follows out_ready).

  logic                     s1_valid_q, s1_valid_d;
  s1_payload_t              s1_data_q, s1_data_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_result_q, out_result_d;
  logic                     out_ovf_q, out_ovf_d;
  logic                     ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0]         ovf_count_q, ovf_count_d;

  logic                     s2_adv, s1_adv, ovf_evt;
  logic signed [DATA_W-1:0] diff, sat_result;
  logic                     diff_ovf;

  sub_8bit_signed u_sub (
    .A        (s1_data_q.a),
    .B        (s1_data_q.b),
    .result   (diff),
    .overflow (diff_ovf)
  );

  always_comb begin
    s2_adv  = !out_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    ovf_evt = out_valid_q && out_ready && out_ovf_q;

    sat_result = diff;
    if ((SAT_EN != 0) && diff_ovf) begin
      sat_result = s1_data_q.a[DATA_W-1] ? SMIN : SMAX;
    end

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = '{a: a, b: b};
      end
    end

    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = sat_result;
        out_ovf_d    = diff_ovf;
      end
    end

    // A delivered overflow takes priority over a coincident clear.
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (ovf_evt) begin
      ovf_sticky_d = 1'b1;
      if (ovf_clr) begin
        ovf_count_d = CNT_W'(1);
      end else if (ovf_count_q != {CNT_W{1'b1}}) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_sub_sat_pipe_8bit.sv
// Directed bench: a saturating instance (CNT_W=8) and a wrapping instance (CNT_W=2) share all inputs.
module tb_sub_sat_pipe_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       out_ready;
  logic       ovf_clr;

  logic       in_ready_s, out_valid_s, out_ovf_s, ovf_sticky_s;
  logic [7:0] out_result_s, ovf_count_s;
  logic       in_ready_w, out_valid_w, out_ovf_w, ovf_sticky_w;
  logic [7:0] out_result_w;
  logic [1:0] ovf_count_w;

  int n_checks = 0;
  int n_errors = 0;

  // {sat ovf, sat result, wrap ovf, wrap result}
  logic [17:0] exp_q[$];

  sub_sat_pipe_8bit #(.SAT_EN(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_result(out_result_s), .out_ovf(out_ovf_s), .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky_s), .ovf_count(ovf_count_s)
  );

  sub_sat_pipe_8bit #(.SAT_EN(0), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_result(out_result_w), .out_ovf(out_ovf_w), .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky_w), .ovf_count(ovf_count_w)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: outputs transfer on the edge following a negedge where valid && ready
  always @(negedge clk) begin
    if (rst_n && out_valid_s && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(1), 32'(0));
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("sat_result", 32'({out_ovf_s, out_result_s}), 32'(e[17:9]));
        check("wrap_result", 32'({out_valid_w, out_ovf_w, out_result_w}), 32'({1'b1, e[8:0]}));
      end
    end
  end

  // driver tasks: called and returning at posedge + #1
  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [8:0] es, input logic [8:0] ew);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = va;
    b = vb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_s) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back({es, ew});
    else check("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic stats(input string tag, input logic [7:0] cs, input logic [1:0] cw, input logic st);
    check({tag, "_cnt_sat"}, 32'(ovf_count_s), 32'(cs));
    check({tag, "_cnt_wrap"}, 32'(ovf_count_w), 32'(cw));
    check({tag, "_sticky"}, 32'({ovf_sticky_s, ovf_sticky_w}), 32'({st, st}));
  endtask

  logic [7:0] bp_a[4] = '{8'd10, 8'hCE, 8'd20, 8'd127};
  logic [7:0] bp_b[4] = '{8'd3, 8'd100, 8'hE2, 8'hFF};
  logic [8:0] bp_s[4] = '{9'h007, 9'h180, 9'h032, 9'h17F};
  logic [8:0] bp_w[4] = '{9'h007, 9'h16A, 9'h032, 9'h180};

  logic [7:0] ov_a[5] = '{8'd100, 8'h80, 8'h9C, 8'd50, 8'hFE};
  logic [7:0] ov_b[5] = '{8'h9C, 8'd1, 8'd100, 8'h9C, 8'd127};
  logic [8:0] ov_s[5] = '{9'h17F, 9'h180, 9'h180, 9'h17F, 9'h180};
  logic [8:0] ov_w[5] = '{9'h1C8, 9'h17F, 9'h138, 9'h196, 9'h17F};

  initial begin
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; ovf_clr = 1'b0;

    // reset state
    #12;
    check("rst_out_valid", 32'({out_valid_s, out_valid_w}), 32'(0));
    check("rst_in_ready", 32'({in_ready_s, in_ready_w}), 32'(2'b11));
    check("rst_out", 32'({out_ovf_s, out_result_s, out_ovf_w, out_result_w}), 32'(0));
    stats("rst", 8'd0, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // latency: accept on edge P1, out_valid after P2
    send(8'd5, 8'd3, 9'h002, 9'h002);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid_s), 32'(0));
    @(negedge clk);
    check("lat_valid", 32'(out_valid_s), 32'(1));
    check("lat_result", 32'(out_result_s), 32'(8'd2));
    @(posedge clk); #1;

    send(8'd100, 8'h9C, 9'h17F, 9'h1C8);
    send(8'h80, 8'd1, 9'h180, 9'h17F);
    send(8'h80, 8'h80, 9'h000, 9'h000);
    drain();
    stats("basic", 8'd2, 2'd2, 1'b1);

    // backpressure: 4 offered, only 2 fit while out_ready is low
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; a = bp_a[0]; b = bp_b[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) check("bp_hold_mid", 32'(out_result_s), 32'(8'd7));
      if (in_ready_s) begin
        exp_q.push_back({bp_s[idx], bp_w[idx]});
        idx++;
      end
      @(posedge clk); #1;
      a = bp_a[idx]; b = bp_b[idx];
    end
    check("bp_accepted", 32'(idx), 32'(2));
    check("bp_in_ready", 32'(in_ready_s), 32'(0));
    check("bp_hold", 32'({out_valid_s, out_ovf_s, out_result_s}), 32'({2'b10, 8'd7}));
    out_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      @(negedge clk);
      if (in_ready_s) begin
        exp_q.push_back({bp_s[idx], bp_w[idx]});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin
        a = bp_a[idx]; b = bp_b[idx];
      end
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'(4));
    drain();
    stats("bp", 8'd4, 2'd3, 1'b1);

    // clear alone
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    stats("clr", 8'd0, 2'd0, 1'b0);

    // five overflow events: narrow counter saturates
    for (int i = 0; i < 5; i++) send(ov_a[i], ov_b[i], ov_s[i], ov_w[i]);
    drain();
    stats("sat5", 8'd5, 2'd3, 1'b1);

    // sixth event coincident with clear: event wins
    out_ready = 1'b0;
    send(8'd120, 8'hF6, 9'h17F, 9'h182);
    for (int i = 0; i < 10 && !out_valid_s; i++) @(negedge clk);
    check("clr_evt_valid", 32'(out_valid_s), 32'(1));
    @(posedge clk); #1;
    ovf_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("clr_evt_q", 32'(exp_q.size()), 32'(0));
    stats("clr_evt", 8'd1, 2'd1, 1'b1);

    // reset with two transactions in flight
    out_ready = 1'b0;
    send(8'd1, 8'd1, 9'h000, 9'h000);
    send(8'd2, 8'd1, 9'h001, 9'h001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'({out_valid_s, out_valid_w}), 32'(0));
    check("mid_rst_ready", 32'(in_ready_s), 32'(1));
    stats("mid_rst", 8'd0, 2'd0, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", 32'({out_valid_s, out_valid_w}), 32'(0));
    end
    @(posedge clk); #1;

    // first accept right after release
    send(8'hF6, 8'd20, 9'h0E2, 9'h0E2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
